// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Brief  : Screen constants, drop-controller state encoding and a saturating helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int H_RES = 1024;
    localparam int V_RES = 768;

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        FALL   = 2'd1,
        LANDED = 2'd2
    } state_t;

    function automatic logic [11:0] sat12(input logic [12:0] v);
        return v[12] ? 12'hFFF : v[11:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module : tick_gen
// Brief  : Free-running 0..TICK_DIV-1 counter with synchronous clear; tick on the last count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int TICK_DIV = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/rect_drop_ctl.sv
// ============================================================================
// Module : rect_drop_ctl
// Brief  : Rectangle follows the mouse, drops under gravity on a left press, rests on the floor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rect_drop_ctl
    import vga_pkg::*;
#(
    parameter int TICK_DIV  = 65000,
    parameter int GRAVITY   = 16,
    parameter int VEL_SHIFT = 4,
    parameter int FLOOR_Y   = V_RES,
    parameter int RECT_H    = 64
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        falling,
    output logic        landed
);

    localparam logic [11:0] C_Y_LIM   = 12'(FLOOR_Y - RECT_H);
    localparam logic [12:0] C_GRAVITY = 13'(GRAVITY);

    state_t      r_state;
    state_t      w_next;
    logic        r_left_d;
    logic        r_arm;
    logic [11:0] r_vel;
    logic        w_press;
    logic        w_tick;
    logic        w_clr;
    logic [11:0] w_xpos_n;
    logic [11:0] w_ypos_n;
    logic [11:0] w_vel_n;
    logic [11:0] w_step;
    logic [12:0] w_sum;

    // r_arm masks the first cycle after reset, so a button held through
    // reset needs a release and a fresh press before it can start a fall.
    assign w_press = mouse_left & ~r_left_d & r_arm;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (pclk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state  <= FOLLOW;
            r_left_d <= 1'b0;
            r_arm    <= 1'b0;
            r_vel    <= '0;
            xpos     <= '0;
            ypos     <= '0;
            falling  <= 1'b0;
            landed   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_left_d <= mouse_left;
            r_arm    <= 1'b1;
            r_vel    <= w_vel_n;
            xpos     <= w_xpos_n;
            ypos     <= w_ypos_n;
            falling  <= (w_next == FALL);
            landed   <= (w_next == LANDED);
        end
    end

    always_comb begin
        w_next   = r_state;
        w_xpos_n = xpos;
        w_ypos_n = ypos;
        w_vel_n  = r_vel;
        w_clr    = 1'b0;
        w_step   = r_vel >> VEL_SHIFT;
        w_sum    = {1'b0, ypos} + {1'b0, w_step};

        case (r_state)
            FOLLOW: begin
                if (w_press) begin
                    w_next  = FALL;
                    w_vel_n = '0;
                    w_clr   = 1'b1;
                end else begin
                    w_xpos_n = mouse_xpos;
                    w_ypos_n = (mouse_ypos > C_Y_LIM) ? C_Y_LIM : mouse_ypos;
                end
            end
            FALL: begin
                if (w_tick) begin
                    w_vel_n = sat12({1'b0, r_vel} + C_GRAVITY);
                    if (w_sum >= {1'b0, C_Y_LIM}) begin
                        w_ypos_n = C_Y_LIM;
                        w_next   = LANDED;
                    end else begin
                        w_ypos_n = w_sum[11:0];
                    end
                end
            end
            LANDED: begin
                if (w_press) begin
                    w_next = FOLLOW;
                end
            end
            default: begin
                w_next = FOLLOW;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_rect_drop_ctl.sv
// ============================================================================
// Module : tb_rect_drop_ctl
// Brief  : Directed scoreboard bench for rect_drop_ctl with TICK_DIV=4.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rect_drop_ctl;

    localparam int TD = 4;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        f;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic        mouse_left = 1'b0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        falling;
    logic        landed;

    int compared   = 0;
    int mismatched = 0;
    exp_t exp_q[$];

    rect_drop_ctl #(
        .TICK_DIV  (TD),
        .GRAVITY   (16),
        .VEL_SHIFT (4),
        .FLOOR_Y   (768),
        .RECT_H    (64)
    ) dut (
        .pclk       (clk),
        .rst        (rst),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .xpos       (xpos),
        .ypos       (ypos),
        .falling    (falling),
        .landed     (landed)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] x, input logic [11:0] y,
                        input logic f, input logic l);
        exp_t e;
        e.x = x; e.y = y; e.f = f; e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, ".xpos"},    xpos,            e.x);
            cmp({tag, ".ypos"},    ypos,            e.y);
            cmp({tag, ".falling"}, {11'd0, falling}, {11'd0, e.f});
            cmp({tag, ".landed"},  {11'd0, landed},  {11'd0, e.l});
        end
    endtask

    initial begin
        // reset state
        step(); step();
        push(0, 0, 0, 0); check("reset");

        // follow and clamp
        rst = 1'b0; mouse_xpos = 300; mouse_ypos = 100;
        step(); push(300, 100, 0, 0); check("follow");
        mouse_xpos = 310; mouse_ypos = 900;
        step(); push(310, 704, 0, 0); check("clamp900");
        mouse_ypos = 704;
        step(); push(310, 704, 0, 0); check("clamp704");
        mouse_ypos = 703;
        step(); push(310, 703, 0, 0); check("noclamp703");
        mouse_xpos = 300; mouse_ypos = 100;
        step(); push(300, 100, 0, 0); check("follow2");

        // press starts the fall; the first tick lands TD cycles after the press
        mouse_left = 1'b1;
        step(); push(300, 100, 1, 0); check("press");
        mouse_xpos = 500; mouse_ypos = 500;
        for (int k = 1; k <= 36; k++) begin
            for (int j = 0; j < TD; j++) begin
                if (k == 1  && j == 0) mouse_left = 1'b0;
                if (k == 10 && j == 1) mouse_left = 1'b1;
                if (k == 10 && j == 2) mouse_left = 1'b0;
                if (k == 36 && j == TD - 1) mouse_left = 1'b1;
                step();
            end
            if (k == 36) push(300, 704, 0, 1);
            else         push(300, 12'(100 + k * (k - 1) / 2), 1, 0);
            check($sformatf("tick%0d", k));
        end
        step(); step();
        push(300, 704, 0, 1); check("landed_hold");

        // press in LANDED returns to following
        mouse_left = 1'b0;
        step();
        mouse_xpos = 50; mouse_ypos = 50; mouse_left = 1'b1;
        step(); push(300, 704, 0, 0); check("unland");
        step(); push(50, 50, 0, 0); check("refollow");

        // reset mid-fall, button held through reset
        mouse_left = 1'b0; mouse_xpos = 300; mouse_ypos = 100;
        step(); push(300, 100, 0, 0); check("follow3");
        mouse_left = 1'b1;
        step(); push(300, 100, 1, 0); check("press2");
        repeat (3 * TD) step();
        push(300, 103, 1, 0); check("fall3");
        rst = 1'b1;
        step(); push(0, 0, 0, 0); check("midreset");
        rst = 1'b0;
        step(); push(300, 100, 0, 0); check("post_reset");
        step(); step(); step();
        push(300, 100, 0, 0); check("held_no_fall");
        mouse_left = 1'b0;
        step();
        mouse_left = 1'b1;
        step(); push(300, 100, 1, 0); check("repress");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
